// File: rtl/sync_fifo_ctrl.sv
// Counter-based FIFO controller that masters both ports of a dp_ram.
// Push/pop are gated by full/empty flags decoded from the registered occupancy count.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_TH      = (2**ADDR_WIDTH) - 4,
  parameter int AE_TH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_w_enable,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_enable,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AE_TH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rd_valid, r_overflow, r_underflow;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign ram_w_enable = w_wr_acc;
  assign ram_w_addr   = r_wr_ptr;
  assign ram_w_data   = wr_data;
  assign ram_r_enable = w_rd_acc;
  assign ram_r_addr   = r_rd_ptr;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign count        = r_count;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = ram_r_data;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations, against a local dp_ram model.
module tb_sync_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 2**AW;

  logic          clk, rst_n, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data, ram_w_data, ram_r_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;
  logic          ram_w_enable, ram_r_enable;
  logic [AW-1:0] ram_w_addr, ram_r_addr;

  int checks = 0;
  int failures = 0;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_TH(4), .AE_TH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .ram_w_enable(ram_w_enable), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_enable(ram_r_enable), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dp_ram stand-in: registered read, one-cycle latency, contents survive reset
  logic [DW-1:0] mem [DEPTH];
  initial ram_r_data = '0;
  always @(posedge clk) begin
    if (ram_w_enable) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_enable) ram_r_data <= mem[ram_r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; addresses are push/pop totals modulo DEPTH
  logic [DW-1:0] q[$];
  int  m_wa = 0, m_ra = 0;
  bit  m_vld = 0, m_ovf = 0, m_unf = 0;
  logic [DW-1:0] m_rdata = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_wa = 0; m_ra = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
    end else begin
      bit wa, ra;
      wa = wr_en && (q.size() < DEPTH);
      ra = rd_en && (q.size() > 0);
      m_ovf = wr_en && (q.size() == DEPTH);
      m_unf = rd_en && (q.size() == 0);
      m_vld = ra;
      if (ra) begin
        m_rdata = q.pop_front();
        m_ra = (m_ra + 1) % DEPTH;
      end
      if (wa) begin
        q.push_back(wr_data);
        m_wa = (m_wa + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    bit ew, er;
    n  = q.size();
    ew = rst_n && wr_en && (n < DEPTH);
    er = rst_n && rd_en && (n > 0);
    chk("m_count", count, n);
    chk("m_empty", empty, n == 0);
    chk("m_full", full, n == DEPTH);
    chk("m_almost_full", almost_full, n >= 4);
    chk("m_almost_empty", almost_empty, n <= 4);
    chk("m_rd_valid", rd_valid, m_vld);
    chk("m_overflow", overflow, m_ovf);
    chk("m_underflow", underflow, m_unf);
    chk("m_ram_w_enable", ram_w_enable, ew);
    chk("m_ram_r_enable", ram_r_enable, er);
    if (ew) begin
      chk("m_ram_w_addr", ram_w_addr, m_wa);
      chk("m_ram_w_data", ram_w_data, wr_data);
    end
    if (er) chk("m_ram_r_addr", ram_r_addr, m_ra);
    if (m_vld) chk("m_rd_data", rd_data, m_rdata);
  end

  task automatic pre(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en = w; wr_data = d; rd_en = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    pre(1'b1, d, 1'b0); step();
  endtask

  task automatic pop();
    pre(1'b0, '0, 1'b1); step();
  endtask

  int wa_exp [6];

  initial begin
    wa_exp = '{5, 6, 7, 0, 1, 2};
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    #1 rst_n = 1'b1;

    // fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      pre(1'b1, 8'(i), 1'b0);
      chk("fill_w_addr", ram_w_addr, i - 1);
      step();
      chk("fill_count", count, i);
      chk("fill_almost_full", almost_full, i >= 4);
    end
    chk("fill_full", full, 1);

    pre(1'b1, 8'hAA, 1'b0);
    chk("ovf_w_enable", ram_w_enable, 0);
    step();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 8);
    step();
    chk("ovf_one_cycle", overflow, 0);

    for (int i = 1; i <= 8; i++) begin
      pop();
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_count", count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    pop();
    chk("unf_pulse", underflow, 1);
    chk("unf_valid", rd_valid, 0);

    // wrap-around
    for (int k = 0; k < 5; k++) push(8'(8'h20 + k));
    for (int k = 0; k < 5; k++) pop();
    for (int k = 0; k < 6; k++) begin
      pre(1'b1, 8'(8'h30 + k), 1'b0);
      chk("wrap_w_addr", ram_w_addr, wa_exp[k]);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      pop();
      chk("wrap_data", rd_data, 8'h30 + k);
    end
    chk("wrap_count", count, 0);

    // simultaneous push/pop at count 3
    for (int k = 0; k < 3; k++) push(8'(8'h40 + k));
    pre(1'b1, 8'h43, 1'b1);
    chk("sim3_w_enable", ram_w_enable, 1);
    chk("sim3_r_enable", ram_r_enable, 1);
    step();
    chk("sim3_count", count, 3);
    chk("sim3_data", rd_data, 8'h40);
    for (int k = 0; k < 3; k++) pop();

    // simultaneous at empty
    pre(1'b1, 8'h50, 1'b1);
    step();
    chk("sim0_count", count, 1);
    chk("sim0_underflow", underflow, 1);
    chk("sim0_valid", rd_valid, 0);

    // simultaneous at full
    for (int k = 1; k < 8; k++) push(8'(8'h50 + k));
    chk("sim8_full", full, 1);
    pre(1'b1, 8'h99, 1'b1);
    chk("sim8_w_enable", ram_w_enable, 0);
    chk("sim8_r_enable", ram_r_enable, 1);
    step();
    chk("sim8_overflow", overflow, 1);
    chk("sim8_count", count, 7);
    chk("sim8_data", rd_data, 8'h50);

    // reset with a pop in flight
    pop(); pop();
    chk("mr_count5", count, 5);
    pop();
    chk("mr_valid_before", rd_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid_drop", rd_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pop();
    chk("mr_first_pop_unf", underflow, 1);
    chk("mr_first_pop_valid", rd_valid, 0);
    chk("mr_empty_after", empty, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
